// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mcpu_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_EXEC_I    = 4'd9,
      S_I_WB      = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_SLL  = 3'd2;
   localparam logic [2:0] ALU_SRL  = 3'd3;
   localparam logic [2:0] ALU_AND  = 3'd4;
   localparam logic [2:0] ALU_OR   = 3'd5;
   localparam logic [2:0] ALU_SLT  = 3'd6;
   localparam logic [2:0] ALU_SLTU = 3'd7;

   localparam logic [1:0] RD_NONE   = 2'd0;
   localparam logic [1:0] RD_WORD   = 2'd1;
   localparam logic [1:0] RD_HALF_S = 2'd2;
   localparam logic [1:0] RD_HALF_U = 2'd3;

   localparam logic [1:0] SRCB_REG     = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       i_or_d;
      logic [1:0] mem_read_mode;
      logic       pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_sel;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
   } ctl_t;

   function automatic logic [1:0] read_mode(input logic [5:0] op);
      case (op)
         OP_LH:   return RD_HALF_S;
         OP_LHU:  return RD_HALF_U;
         default: return RD_WORD;
      endcase
   endfunction

   // Moore control word for a state; sel/rmode come from the (stable) IR fields.
   function automatic ctl_t ctl_for(input state_t s, input logic [2:0] sel,
                                    input logic [1:0] rmode, input logic run);
      ctl_t c;
      c = '0;
      c.mem_read_mode = RD_NONE;
      c.alu_src_b     = SRCB_REG;
      c.alu_sel       = ALU_ADD;
      case (s)
         S_FETCH: begin
            c.mem_req       = run;
            c.mem_read_mode = RD_WORD;
            c.alu_src_b     = SRCB_FOUR;
         end
         S_DECODE:    c.alu_src_b = SRCB_IMM_SL2;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            c.mem_req       = 1'b1;
            c.i_or_d        = 1'b1;
            c.mem_read_mode = rmode;
         end
         S_MEM_WB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_sel   = sel;
         end
         S_R_WB: begin
            c.reg_dst    = 1'b1;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = 1'b1;
            c.alu_sel    = ALU_SUB;
            c.pc_src     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_sel   = sel;
         end
         S_I_WB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - unified memory port handshake between sequencer and memory
interface multicycle_control_fsm_if;
   logic       mem_req;
   logic       mem_write;
   logic       i_or_d;
   logic [1:0] mem_read_mode;
   logic       mem_ready;

   modport master (output mem_req, mem_write, i_or_d, mem_read_mode, input mem_ready);
   modport slave  (input mem_req, mem_write, i_or_d, mem_read_mode, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// rtl/multicycle_control_fsm_alu_op_decoder.sv - opcode/funct to alu_sel and legality
module alu_op_decoder
   import mcpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_sel,
   output logic       legal
);
   always_comb begin
      alu_sel = ALU_ADD;
      legal   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            legal = 1'b1;
            case (funct)
               F_ADD:   alu_sel = ALU_ADD;
               F_SUB:   alu_sel = ALU_SUB;
               F_SLL:   alu_sel = ALU_SLL;
               F_SRL:   alu_sel = ALU_SRL;
               F_AND:   alu_sel = ALU_AND;
               F_OR:    alu_sel = ALU_OR;
               F_SLT:   alu_sel = ALU_SLT;
               F_SLTU:  alu_sel = ALU_SLTU;
               default: legal   = 1'b0;
            endcase
         end
         OP_LW, OP_LH, OP_LHU, OP_SW, OP_ADDI: legal = 1'b1;
         OP_BEQ: begin
            alu_sel = ALU_SUB;
            legal   = 1'b1;
         end
         OP_ANDI: begin
            alu_sel = ALU_AND;
            legal   = 1'b1;
         end
         OP_ORI: begin
            alu_sel = ALU_OR;
            legal   = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle MIPS sequencer driving datapath selects and strobes
module multicycle_control_fsm
   import mcpu_pkg::*;
#(
   parameter int STATE_W        = 4,
   parameter int FETCH_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [5:0]               opcode,
   input  logic [5:0]               funct,
   input  logic                     zero,
   multicycle_control_fsm_if.master mem,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic                     pc_src,
   output logic                     alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [2:0]               alu_sel,
   output logic                     reg_dst,
   output logic                     mem_to_reg,
   output logic                     reg_write,
   output logic                     instr_done,
   output logic                     illegal_op,
   output logic [STATE_W-1:0]       state
);
   state_t     cur_state, nxt_state;
   ctl_t       ctl_q;
   logic       run_q, run, act, fetch_ok, legal;
   logic [2:0] dec_sel;

   alu_op_decoder u_alu_op_decoder (
      .opcode  (opcode),
      .funct   (funct),
      .alu_sel (dec_sel),
      .legal   (legal)
   );

   assign act      = ~reset;
   assign run      = (FETCH_ON_RESET != 0) || run_q || start;
   assign fetch_ok = (cur_state == S_FETCH) && ctl_q.mem_req && mem.mem_ready;

   always_comb begin
      nxt_state = S_FETCH;
      case (cur_state)
         S_FETCH:  nxt_state = fetch_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (!legal) nxt_state = S_FETCH;
            else begin
               case (opcode)
                  OP_RTYPE:                    nxt_state = S_EXEC_R;
                  OP_LW, OP_LH, OP_LHU, OP_SW: nxt_state = S_MEM_ADDR;
                  OP_BEQ:                      nxt_state = S_BRANCH;
                  default:                     nxt_state = S_EXEC_I;
               endcase
            end
         end
         S_MEM_ADDR:  nxt_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  nxt_state = mem.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: nxt_state = mem.mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXEC_R:    nxt_state = S_R_WB;
         S_EXEC_I:    nxt_state = S_I_WB;
         default:     nxt_state = S_FETCH;
      endcase
   end

   // Control word is registered from the next state, so outputs are glitch-free Moore values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= S_FETCH;
         run_q     <= 1'b0;
         ctl_q     <= ctl_for(S_FETCH, ALU_ADD, RD_WORD, FETCH_ON_RESET != 0);
      end else begin
         cur_state <= nxt_state;
         run_q     <= run;
         ctl_q     <= ctl_for(nxt_state, dec_sel, read_mode(opcode), run);
      end
   end

   assign mem.mem_req       = act & ctl_q.mem_req;
   assign mem.mem_write     = act & ctl_q.mem_write;
   assign mem.i_or_d        = act & ctl_q.i_or_d;
   assign mem.mem_read_mode = act ? ctl_q.mem_read_mode : RD_NONE;

   assign ir_write   = act & fetch_ok;
   assign pc_write   = act & (fetch_ok | ((cur_state == S_BRANCH) & zero));
   assign pc_src     = act & ctl_q.pc_src;
   assign alu_src_a  = act & ctl_q.alu_src_a;
   assign alu_src_b  = act ? ctl_q.alu_src_b : SRCB_REG;
   assign alu_sel    = act ? ctl_q.alu_sel : ALU_ADD;
   assign reg_dst    = act & ctl_q.reg_dst;
   assign mem_to_reg = act & ctl_q.mem_to_reg;
   assign reg_write  = act & ctl_q.reg_write;
   assign illegal_op = act & (cur_state == S_DECODE) & ~legal;
   assign instr_done = act & (ctl_q.instr_done | illegal_op |
                              ((cur_state == S_MEM_WRITE) & mem.mem_ready));
   assign state      = act ? STATE_W'(cur_state) : '0;
endmodule
